// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory responder for the multicycle MIPS data port; partial stores run as read-modify-write.
// Optional alignment checking with output misalign is enabled by defining DMEM_ALIGN_CHECK_EN.
`default_nettype none

module dmem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  input  logic        dmem_w,
  input  logic        dmem_r,
  input  logic        special_store_signal,
  input  logic        store_half,
  output logic [31:0] dmem_data,
  output logic        ready
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic [31:0]       wr_word;
  logic [ADDR_W-1:0] idx;
  logic              mem_we;
  logic              done;
  logic              bad_align;
  logic              unused_addr_hi;

  assign idx            = data_addr[ADDR_W+1:2];
  assign unused_addr_hi = ^data_addr[31:ADDR_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  // sb is never misaligned; sh needs an even address; everything else is a word access.
  always_comb begin
    bad_align = 1'b0;
    if (dmem_w && special_store_signal)
      bad_align = store_half && data_addr[0];
    else
      bad_align = (data_addr[1:0] != 2'b00);
  end
`else
  assign bad_align = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // While ready is high the CPU still holds the old request, so IDLE must not re-accept it.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    mem_we   = 1'b0;
    case (state)
      IDLE: begin
        if (!ready) begin
          if (dmem_w)
            state_nx = special_store_signal ? RMW_RD : WR;
          else if (dmem_r)
            state_nx = RD;
        end
      end
      RD: begin
        state_nx = IDLE;
        done     = 1'b1;
      end
      WR: begin
        state_nx = IDLE;
        done     = 1'b1;
        mem_we   = !bad_align;
      end
      RMW_RD: begin
        state_nx = RMW_WR;
      end
      RMW_WR: begin
        state_nx = IDLE;
        done     = 1'b1;
        mem_we   = !bad_align;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    if (store_half) begin
      if (data_addr[1])
        merged[31:16] = w_data[15:0];
      else
        merged[15:0]  = w_data[15:0];
    end else begin
      case (data_addr[1:0])
        2'd0:    merged[7:0]   = w_data[7:0];
        2'd1:    merged[15:8]  = w_data[7:0];
        2'd2:    merged[23:16] = w_data[7:0];
        default: merged[31:24] = w_data[7:0];
      endcase
    end
  end

  assign wr_word = (state == RMW_WR) ? merged : w_data;

  // rd_word tracks the addressed word every cycle; inputs are stable from acceptance onward.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[idx] <= wr_word;
    rd_word <= mem[idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_data <= 32'h0;
      ready     <= 1'b0;
      old_word  <= 32'h0;
    end else begin
      ready <= done;
      if (state == RMW_RD)
        old_word <= rd_word;
      if (state == RD && !bad_align)
        dmem_data <= rd_word;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      misalign <= 1'b0;
    else
      misalign <= done && bad_align;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed test-plan steps followed by random traffic against a word-array model.
`default_nettype none

module tb_dmem_ctrl;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] w_data;
  logic        dmem_w;
  logic        dmem_r;
  logic        special_store_signal;
  logic        store_half;
  logic [31:0] dmem_data;
  logic        ready;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .data_addr            (data_addr),
    .w_data               (w_data),
    .dmem_w               (dmem_w),
    .dmem_r               (dmem_r),
    .special_store_signal (special_store_signal),
    .store_half           (store_half),
    .dmem_data            (dmem_data),
    .ready                (ready)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misalign             (misalign)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [1:0] lo, input logic half);
    int          sh;
    logic [31:0] mask;
    if (half) begin
      sh   = int'(lo[1]) * 16;
      mask = 32'h0000FFFF << sh;
    end else begin
      sh   = int'(lo) * 8;
      mask = 32'h000000FF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic logic is_mis(input logic w, input logic sp, input logic hf, input logic [1:0] lo);
`ifdef DMEM_ALIGN_CHECK_EN
    if (w && sp) return hf && lo[0];
    return lo != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic idle_inputs();
    dmem_w = 0; dmem_r = 0; special_store_signal = 0; store_half = 0;
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge.
  task automatic req(input logic w, input logic r, input logic sp, input logic hf,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    int          idx;
    int          edges;
    int          exp_lat;
    logic        got;
    logic        mis;
    logic [31:0] exp_data;
    idx      = int'(a[ADDR_W+1:2]);
    mis      = is_mis(w, sp, hf, a[1:0]);
    exp_lat  = (w && sp) ? 3 : 2;
    exp_data = (!w && !mis) ? model[idx] : last_rd;
    data_addr = a; w_data = d; dmem_w = w; dmem_r = r;
    special_store_signal = sp; store_half = hf;
    edges = 0; got = 1'b0;
    while (!got && edges < 8) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    check({tag, "/latency"}, 32'(edges), 32'(exp_lat));
    check({tag, "/data"}, dmem_data, exp_data);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, "/misalign"}, {31'b0, misalign}, {31'b0, mis});
`endif
    if (w && !mis)
      model[idx] = sp ? merge(model[idx], d, a[1:0], hf) : d;
    last_rd = exp_data;
    idle_inputs();
    @(posedge clk); #1;
    check({tag, "/ready_pulse"}, {31'b0, ready}, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    check({tag, "/misalign_clr"}, {31'b0, misalign}, 32'h0);
`endif
  endtask

  // Start an sb, pulse reset after n_edges edges (1 = in RMW_RD, 2 = in RMW_WR), confirm no completion.
  task automatic abort_rmw(input int n_edges, input logic [31:0] a, input string tag);
    logic seen;
    data_addr = a; w_data = 32'h000000FF; dmem_w = 1; dmem_r = 0;
    special_store_signal = 1; store_half = 0;
    repeat (n_edges) @(posedge clk);
    #2 rst = 1'b1;
    idle_inputs();
    #1;
    check({tag, "/rst_ready"}, {31'b0, ready}, 32'h0);
    check({tag, "/rst_data"}, dmem_data, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    last_rd = 32'h0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ready;
    end
    check({tag, "/no_ready"}, {31'b0, seen}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          kind;
    rst = 1'b1;
    data_addr = 0; w_data = 0;
    idle_inputs();
    last_rd = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/ready", {31'b0, ready}, 32'h0);
    check("reset/data", dmem_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    req(1, 0, 0, 0, 32'h0000_0000, 32'hDEADBEEF, "sw0");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw0");
    check("lw0/const", dmem_data, 32'hDEADBEEF);

    // asynchronous reset mid-cycle: outputs clear before any clock edge
    #2 rst = 1'b1;
    #1;
    check("async_rst/data", dmem_data, 32'h0);
    check("async_rst/ready", {31'b0, ready}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    last_rd = 32'h0;

    req(1, 0, 1, 0, 32'h0000_0001, 32'h000000AB, "sb1");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw_after_sb");
    check("lw_after_sb/const", dmem_data, 32'hDEADABEF);
    req(1, 0, 1, 1, 32'h0000_0002, 32'h00001234, "sh2");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw_after_sh");
    check("lw_after_sh/const", dmem_data, 32'h1234ABEF);

    req(1, 1, 0, 0, 32'h0000_1000, 32'h11223344, "sw_alias_rw");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw_alias");
    check("lw_alias/const", dmem_data, 32'h11223344);

    abort_rmw(1, 32'h0000_0003, "abort_rmw_rd");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw_after_abort1");
    check("lw_after_abort1/const", dmem_data, 32'h11223344);
    abort_rmw(2, 32'h0000_0003, "abort_rmw_wr");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw_after_abort2");
    check("lw_after_abort2/const", dmem_data, 32'h11223344);

    req(1, 0, 1, 1, 32'h0000_0001, 32'h0000BEEF, "sh_odd");
    req(0, 1, 0, 0, 32'h0000_0000, 32'h0, "lw_after_sh_odd");
`ifdef DMEM_ALIGN_CHECK_EN
    check("lw_after_sh_odd/const", dmem_data, 32'h11223344);
`else
    check("lw_after_sh_odd/const", dmem_data, 32'h1122BEEF);
`endif

    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'(i) << 2);
      req(1, 0, 0, 0, a, $urandom, "rnd_init");
    end
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      case (kind)
        0:       req(0, 1, 0, 0, a, $urandom, "rnd_lw");
        1:       req(1, 1'($urandom_range(0, 1)), 0, 0, a, $urandom, "rnd_sw");
        2:       req(1, 1'($urandom_range(0, 1)), 1, 0, a, $urandom, "rnd_sb");
        default: req(1, 1'($urandom_range(0, 1)), 1, 1, a, $urandom, "rnd_sh");
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
